// File: rtl/pipelined_barrel_shifter_with_valid_ready_if.sv
// Handshake bundle for the pipelined barrel shifter: upstream operand
// channel and downstream result channel.
interface pipelined_barrel_shifter_with_valid_ready_if #(
   parameter int N = 8
);
   localparam int SW = $clog2(N);

   logic          up_valid;
   logic          up_ready;
   logic [N-1:0]  up_data;
   logic [SW-1:0] up_shamt;
   logic          up_dir;
   logic          up_arith;
   logic          down_valid;
   logic          down_ready;
   logic [N-1:0]  down_data;

   // Environment side: produces operands, consumes results.
   modport master (
      output up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
      input  up_ready, down_valid, down_data
   );

   // Shifter side.
   modport slave (
      input  up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
      output up_ready, down_valid, down_data
   );
endinterface

// File: rtl/pipelined_barrel_shifter_with_valid_ready.sv
// log2(N)-stage pipelined barrel shifter. Stage k shifts by 2**k when bit k
// of the carried shift amount is set. Each stage has its own valid bit and a
// ready chain, so bubbles collapse even while the output is stalled.
module pipelined_barrel_shifter_with_valid_ready #(
   parameter int N = 8
) (
   input logic clk,
   input logic rst_n,
   pipelined_barrel_shifter_with_valid_ready_if.slave bus
);
   localparam int SW = $clog2(N);

   // stage registers
   logic          vld  [SW];
   logic [N-1:0]  dat  [SW];
   logic [SW-1:0] amt  [SW];
   logic          dir  [SW];
   logic          fill [SW];

   // ready chain, rdy[SW] is the downstream ready
   logic          rdy  [SW+1];

   // per-stage inputs and shifted data
   logic          in_v    [SW];
   logic [N-1:0]  in_d    [SW];
   logic [SW-1:0] in_a    [SW];
   logic          in_dir  [SW];
   logic          in_fill [SW];
   logic [N-1:0]  nx_d    [SW];

   // A stage can load when it is empty or its successor is moving.
   always_comb begin
      rdy[SW] = bus.down_ready;
      for (int unsigned i = 0; i < SW; i++) begin
         rdy[SW-1-i] = !vld[SW-1-i] | rdy[SW-i];
      end
   end

   // Select each stage's source and apply that stage's conditional 2**k shift.
   always_comb begin
      in_v[0]    = bus.up_valid & rdy[0];
      in_d[0]    = bus.up_data;
      in_a[0]    = bus.up_shamt;
      in_dir[0]  = bus.up_dir;
      in_fill[0] = bus.up_dir & bus.up_arith & bus.up_data[N-1];
      for (int unsigned k = 1; k < SW; k++) begin
         in_v[k]    = vld[k-1];
         in_d[k]    = dat[k-1];
         in_a[k]    = amt[k-1];
         in_dir[k]  = dir[k-1];
         in_fill[k] = fill[k-1];
      end
      for (int unsigned k = 0; k < SW; k++) begin
         nx_d[k] = in_d[k];
         if (in_a[k][k]) begin
            if (in_dir[k]) begin
               nx_d[k] = (in_d[k] >> (1 << k))
                       | ({N{in_fill[k]}} & ~({N{1'b1}} >> (1 << k)));
            end else begin
               nx_d[k] = in_d[k] << (1 << k);
            end
         end
      end
   end

   // Pipeline registers: load when ready, otherwise hold contents and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < SW; k++) begin
            vld[k]  <= 1'b0;
            dat[k]  <= '0;
            amt[k]  <= '0;
            dir[k]  <= 1'b0;
            fill[k] <= 1'b0;
         end
      end else begin
         for (int unsigned k = 0; k < SW; k++) begin
            if (rdy[k]) begin
               vld[k]  <= in_v[k];
               dat[k]  <= nx_d[k];
               amt[k]  <= in_a[k];
               dir[k]  <= in_dir[k];
               fill[k] <= in_fill[k];
            end
         end
      end
   end

   assign bus.up_ready   = rdy[0];
   assign bus.down_valid = vld[SW-1];
   assign bus.down_data  = dat[SW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter_with_valid_ready.sv
// Self-checking bench for the pipelined barrel shifter (N=8): directed
// vectors, a full-rate stream, random back-pressure and reset mid-flight,
// all scored against a shift-operator reference model and a result queue.
module tb_pipelined_barrel_shifter_with_valid_ready;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pipelined_barrel_shifter_with_valid_ready_if #(.N(8)) bus ();

   pipelined_barrel_shifter_with_valid_ready #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [7:0] q[$];          // expected results, oldest first
   logic       s_dv;          // down_valid seen at the last sample point
   logic [7:0] s_dd;          // down_data seen at the last sample point
   logic       prev_stall = 1'b0;
   logic [7:0] prev_dd = '0;

   function automatic logic [7:0] model(logic [7:0] d, logic [2:0] s, logic dr, logic ar);
      logic signed [7:0] sd;
      logic [7:0] r;
      sd = d;
      if (!dr)     r = d << s;
      else if (ar) r = sd >>> s;
      else         r = d >> s;
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample at the falling edge, score, then advance past the rising edge.
   task automatic cycle();
      logic exp_rdy;
      @(negedge clk);
      s_dv = bus.down_valid;
      s_dd = bus.down_data;
      exp_rdy = !(q.size() == 3 && !bus.down_ready);
      chk("up_ready", {31'd0, bus.up_ready}, {31'd0, exp_rdy});
      if (prev_stall) begin
         chk("stall_valid", {31'd0, bus.down_valid}, 32'd1);
         chk("stall_data", {24'd0, bus.down_data}, {24'd0, prev_dd});
      end
      if (bus.down_valid) begin
         if (q.size() == 0) begin
            chk("spurious_result", 32'd1, 32'd0);
         end else begin
            chk("result_data", {24'd0, bus.down_data}, {24'd0, q[0]});
            if (bus.down_ready) void'(q.pop_front());
         end
      end
      prev_stall = bus.down_valid & !bus.down_ready;
      prev_dd    = bus.down_data;
      if (bus.up_valid && bus.up_ready)
         q.push_back(model(bus.up_data, bus.up_shamt, bus.up_dir, bus.up_arith));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [7:0] d, logic [2:0] s, logic dr, logic ar);
      bus.up_valid = v;
      bus.up_data  = d;
      bus.up_shamt = s;
      bus.up_dir   = dr;
      bus.up_arith = ar;
   endtask

   // Single operand into an idle pipeline; checks latency and the exact result.
   task automatic run_one(string tag, logic [7:0] d, logic [2:0] s, logic dr, logic ar,
                          logic [7:0] exp);
      int lat;
      logic [7:0] got;
      lat = 0;
      got = '0;
      bus.down_ready = 1'b1;
      drive(1'b1, d, s, dr, ar);
      cycle();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cycle();
         if (s_dv && lat == 0) begin
            lat = i;
            got = s_dd;
         end
      end
      chk({tag, "_latency"}, lat, 3);
      chk(tag, {24'd0, got}, {24'd0, exp});
   endtask

   initial begin
      bus.down_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);

      // reset state
      #12;
      chk("rst_down_valid", {31'd0, bus.down_valid}, 32'd0);
      chk("rst_down_data", {24'd0, bus.down_data}, 32'd0);
      chk("rst_up_ready", {31'd0, bus.up_ready}, 32'd1);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors
      run_one("left3",     8'b1011_0110, 3'd3, 1'b0, 1'b0, 8'b1011_0000);
      run_one("lsr3",      8'b1011_0110, 3'd3, 1'b1, 1'b0, 8'b0001_0110);
      run_one("asr3",      8'b1011_0110, 3'd3, 1'b1, 1'b1, 8'b1111_0110);
      run_one("asr7_pos",  8'b0100_0000, 3'd7, 1'b1, 1'b1, 8'b0000_0000);
      run_one("sh0_l",     8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5);
      run_one("sh0_l_ar",  8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5);
      run_one("sh0_lsr",   8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5);
      run_one("sh0_asr",   8'hA5, 3'd0, 1'b1, 1'b1, 8'hA5);
      run_one("left7",     8'hFF, 3'd7, 1'b0, 1'b0, 8'h80);
      run_one("asr7_neg",  8'h80, 3'd7, 1'b1, 1'b1, 8'hFF);

      // full-rate stream of 20 random operands
      bus.down_ready = 1'b1;
      for (int i = 0; i < 23; i++) begin
         if (i < 20)
            drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
         else
            drive(1'b0, '0, '0, 1'b0, 1'b0);
         cycle();
         if (i >= 3) chk("stream_rate", {31'd0, s_dv}, 32'd1);
      end
      chk("stream_drained", q.size(), 0);

      // random valid and back-pressure
      for (int i = 0; i < 300; i++) begin
         bus.down_ready = 1'($urandom);
         drive(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
         cycle();
      end
      bus.down_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cycle();
      chk("random_drained", q.size(), 0);

      // reset with three operands in flight
      bus.down_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h30 + 8'(i), 3'd1, 1'b0, 1'b0);
         cycle();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("full_up_ready", {31'd0, bus.up_ready}, 32'd0);
      chk("full_valid", {31'd0, bus.down_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, bus.down_valid}, 32'd0);
      chk("async_rst_data", {24'd0, bus.down_data}, 32'd0);
      q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.down_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("no_stale", {31'd0, s_dv}, 32'd0);
      end
      run_one("post_reset", 8'h0F, 3'd2, 1'b0, 1'b0, 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
